// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Steps a square-wave tone generator through a fixed note table so a short
//   melody plays on one speaker pin. Each table entry is a half-period (in
//   clocks, 0 = rest) and a duration (in ticks, 0 treated as 1). A silent gap
//   of GAP_TICKS ticks follows every note.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      level input; a sampled rising edge starts playback at note 0
//   stop       level input; aborts playback on the next clock, no done pulse
//   loop       when 1 at the end of the last note, playback wraps to note 0
//   sp         speaker square wave
//   busy       1 in every state other than IDLE
//   note_idx   index of the current note
//   done       one-clock pulse when playback ends normally
//   sp_en      (MELODY_SEQUENCER_ENVELOPE_EN only) 1 while sp may toggle
//   dbg_state  current FSM state (IDLE=0, LOAD=1, PLAY=2, GAP=3)
//
// Handshake: start/stop are plain levels, no valid/ready; start is edge
// detected internally and ignored while busy, stop wins over start.
//
// Optional feature macro: MELODY_SEQUENCER_ENVELOPE_EN adds a staccato
// release: during the last tick of each note sp is masked on alternate
// half-periods.
module melody_sequencer #(
  parameter int CLK_HZ    = 25000000,
  parameter int TICK_HZ   = 100,
  parameter int NUM_NOTES = 8,
  parameter int GAP_TICKS = 2,
  parameter int HP_W      = 20,
  // Entry 0 sits in the least significant slot. Default: C5..C6, 250 ms each.
  parameter logic [15:0][HP_W-1:0] HP_TABLE = {{8{HP_W'(0)}},
    HP_W'(11939), HP_W'(12651), HP_W'(14204), HP_W'(15944),
    HP_W'(17908), HP_W'(18968), HP_W'(21294), HP_W'(23900)},
  parameter logic [15:0][7:0] DUR_TABLE = {{8{8'd0}}, {8{8'd25}}}
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic       sp,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done,
`ifdef MELODY_SEQUENCER_ENVELOPE_EN
  output logic       sp_en,
`endif
  output logic [1:0] dbg_state
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, GAP = 2'd3} state_t;

  state_t            state_q, state_n;
  logic              start_d;
  logic [TW-1:0]     tick_cnt, tick_n;
  logic [HP_W-1:0]   tone_cnt, tone_n;
  logic [HP_W-1:0]   hp_reg, hp_n;
  logic [7:0]        dur_cnt, dur_n;
  logic [3:0]        note_q, note_n;
  logic              sp_q, sp_n;
  logic              done_q, done_n;
  logic              start_rise, tick, advance;
  logic [HP_W-1:0]   rom_hp;
  logic [7:0]        rom_dur;
`ifdef MELODY_SEQUENCER_ENVELOPE_EN
  logic              par_q, par_n;   // flips on every sp toggle
  logic              env_mask;
`endif

  assign start_rise = start & ~start_d;
  assign rom_hp     = HP_TABLE[note_q];
  assign rom_dur    = DUR_TABLE[note_q];
  // The tick counter only moves in PLAY/GAP; it is held at 0 elsewhere.
  assign tick       = (state_q == PLAY || state_q == GAP) && (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      start_d  <= 1'b0;
      tick_cnt <= '0;
      tone_cnt <= '0;
      hp_reg   <= '0;
      dur_cnt  <= '0;
      note_q   <= '0;
      sp_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef MELODY_SEQUENCER_ENVELOPE_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      start_d  <= start;
      tick_cnt <= tick_n;
      tone_cnt <= tone_n;
      hp_reg   <= hp_n;
      dur_cnt  <= dur_n;
      note_q   <= note_n;
      sp_q     <= sp_n;
      done_q   <= done_n;
`ifdef MELODY_SEQUENCER_ENVELOPE_EN
      par_q    <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    tick_n  = tick_cnt;
    tone_n  = tone_cnt;
    hp_n    = hp_reg;
    dur_n   = dur_cnt;
    note_n  = note_q;
    sp_n    = sp_q;
    done_n  = 1'b0;
    advance = 1'b0;
`ifdef MELODY_SEQUENCER_ENVELOPE_EN
    par_n   = par_q;
`endif

    case (state_q)
      IDLE: begin
        sp_n   = 1'b0;
        tick_n = '0;
        tone_n = '0;
        note_n = '0;
        if (start_rise && !stop) state_n = LOAD;
      end
      LOAD: begin
        hp_n    = rom_hp;
        dur_n   = (rom_dur == 8'd0) ? 8'd1 : rom_dur;
        tone_n  = '0;
        tick_n  = '0;
        sp_n    = 1'b0;
        state_n = PLAY;
`ifdef MELODY_SEQUENCER_ENVELOPE_EN
        par_n   = 1'b0;
`endif
      end
      PLAY: begin
        tick_n = tick ? '0 : tick_cnt + 1'b1;
        if (hp_reg == '0) begin
          sp_n = 1'b0;
        end else if (tone_cnt == hp_reg - 1'b1) begin
          // Toggle after exactly hp_reg clocks since the previous toggle.
          tone_n = '0;
          sp_n   = ~sp_q;
`ifdef MELODY_SEQUENCER_ENVELOPE_EN
          par_n  = ~par_q;
`endif
        end else begin
          tone_n = tone_cnt + 1'b1;
        end
        if (tick) begin
          if (dur_cnt == 8'd1) begin
            if (GAP_TICKS > 0) begin
              // dur_cnt is reused as the gap tick counter.
              state_n = GAP;
              dur_n   = 8'(GAP_TICKS);
              tick_n  = '0;
              tone_n  = '0;
              sp_n    = 1'b0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            dur_n = dur_cnt - 8'd1;
          end
        end
      end
      GAP: begin
        sp_n   = 1'b0;
        tick_n = tick ? '0 : tick_cnt + 1'b1;
        if (tick) begin
          if (dur_cnt == 8'd1) advance = 1'b1;
          else                 dur_n   = dur_cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (advance) begin
      sp_n   = 1'b0;
      tone_n = '0;
      tick_n = '0;
      if (note_q < 4'(NUM_NOTES - 1)) begin
        note_n  = note_q + 4'd1;
        state_n = LOAD;
      end else if (loop) begin
        note_n  = '0;
        state_n = LOAD;
      end else begin
        note_n  = '0;
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end

    // Abort overrides everything, including a normal end on the same clock.
    if (stop && state_q != IDLE) begin
      state_n = IDLE;
      sp_n    = 1'b0;
      note_n  = '0;
      tone_n  = '0;
      tick_n  = '0;
      done_n  = 1'b0;
    end
  end

`ifdef MELODY_SEQUENCER_ENVELOPE_EN
  // Last tick of a tonal note: silence every other half-period.
  assign env_mask = (state_q == PLAY) && (dur_cnt == 8'd1) && par_q;
  assign sp       = sp_q & ~env_mask;
  assign sp_en    = (state_q == PLAY) && (hp_reg != '0) && !env_mask;
`else
  assign sp       = sp_q;
`endif

  assign busy      = (state_q != IDLE);
  assign note_idx  = note_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic       sp, busy, done;
  logic [3:0] note_idx;
  logic [1:0] dbg_state;
  logic       start_def = 1'b0;
  logic       sp_def, busy_def, done_def;
  logic [3:0] note_def;
  logic [1:0] state_def;
`ifdef MELODY_SEQUENCER_ENVELOPE_EN
  logic       sp_en, sp_en_def;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // clock/reset block
  always #5 clk = ~clk;

  // Small table: note 0 hp=3 dur=2, note 1 rest dur=1; tick = 10 clocks.
  melody_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .NUM_NOTES(2), .GAP_TICKS(1), .HP_W(20),
    .HP_TABLE(320'd3), .DUR_TABLE(128'h0102)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .sp(sp), .busy(busy), .note_idx(note_idx), .done(done),
`ifdef MELODY_SEQUENCER_ENVELOPE_EN
    .sp_en(sp_en),
`endif
    .dbg_state(dbg_state)
  );

  melody_sequencer u_def (
    .clk(clk), .rst_n(rst_n), .start(start_def), .stop(1'b0), .loop(1'b0),
    .sp(sp_def), .busy(busy_def), .note_idx(note_def), .done(done_def),
`ifdef MELODY_SEQUENCER_ENVELOPE_EN
    .sp_en(sp_en_def),
`endif
    .dbg_state(state_def)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected behaviour of one non-looping pass, k = clocks after the edge
  // that sampled the start rise (sampled at the following falling edge).
  // LOAD k=0, PLAY 1..20, GAP 21..30, LOAD 31, PLAY 32..41, GAP 42..51.
  function automatic int exp_state(int k);
    if (k == 0)  return 1;
    if (k <= 20) return 2;
    if (k <= 30) return 3;
    if (k == 31) return 1;
    if (k <= 41) return 2;
    if (k <= 51) return 3;
    return 0;
  endfunction

  function automatic int exp_sp(int k);
    return (k >= 1 && k <= 20) ? ((k - 1) / 3) % 2 : 0;
  endfunction

  function automatic int exp_note(int k);
    return (k >= 31 && k <= 51) ? 1 : 0;
  endfunction

  task automatic check_cycle(input int k, input bit lp);
    int kk;
    kk = lp ? (k % 52) : k;
    check($sformatf("state k=%0d", k), 32'(dbg_state), 32'(exp_state(kk)));
    check($sformatf("sp k=%0d", k),    32'(sp),        32'(exp_sp(kk)));
    check($sformatf("note k=%0d", k),  32'(note_idx),  32'(exp_note(kk)));
    check($sformatf("busy k=%0d", k),  32'(busy),      32'(exp_state(kk) != 0));
    check($sformatf("done k=%0d", k),  32'(done),      32'(!lp && k == 52));
  endtask

  task automatic check_idle(input string tag);
    check({tag, " state"}, 32'(dbg_state), 32'd0);
    check({tag, " sp"},    32'(sp),        32'd0);
    check({tag, " note"},  32'(note_idx),  32'd0);
    check({tag, " busy"},  32'(busy),      32'd0);
    check({tag, " done"},  32'(done),      32'd0);
  endtask

  initial begin
    int cnt;

    // reset values
    repeat (3) step();
    check_idle("reset");
    check("reset def sp", 32'(sp_def), 32'd0);
    rst_n = 1'b1;
    step();

    // normal playback; second rise at k=10 while busy is ignored,
    // start stays high afterwards so there must be no retrigger
    start = 1'b1;
    step();
    for (int k = 0; k <= 70; k++) begin
      check_cycle(k, 1'b0);
      if (k == 8) start = 1'b0;
      if (k == 9) start = 1'b1;
      step();
    end
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    check("retrigger state", 32'(dbg_state), 32'd1);
    stop = 1'b1;
    step();
    check_idle("stop after retrigger");
    stop = 1'b0;
    start = 1'b0;
    step();

    // looping playback, stopped in the middle of note 1
    loop = 1'b1;
    start = 1'b1;
    step();
    for (int k = 0; k <= 85; k++) begin
      check_cycle(k, 1'b1);
      if (k == 85) stop = 1'b1;
      step();
    end
    check_idle("stop in note1");
    stop = 1'b0;
    loop = 1'b0;
    start = 1'b0;
    step();

    // stop 5 clocks into note 0, then a start rise while stop is high
    start = 1'b1;
    step();
    for (int k = 0; k <= 5; k++) begin
      check_cycle(k, 1'b0);
      if (k == 5) begin
        stop = 1'b1;
        start = 1'b0;
      end
      step();
    end
    check_idle("stop note0");
    start = 1'b1;
    step();
    check_idle("stop beats start");
    stop = 1'b0;
    step();
    check_idle("held start no rise");
    start = 1'b0;
    step();

    // asynchronous reset in the middle of PLAY (sp high at k=5)
    start = 1'b1;
    step();
    for (int k = 0; k <= 5; k++) begin
      check_cycle(k, 1'b0);
      if (k < 5) step();
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle("async reset");
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check_idle("after reset");

    // default parameters: first toggle and measured half-period of note 0
    start_def = 1'b1;
    step();
    start_def = 1'b0;
    cnt = 0;
    while (sp_def == 1'b0 && cnt < 30000) begin
      step();
      cnt++;
    end
    check("def first rise", 32'(cnt), 32'd23901);
    cnt = 0;
    while (sp_def == 1'b1 && cnt < 30000) begin
      step();
      cnt++;
    end
    check("def half period", 32'(cnt), 32'd23900);
    check("def note", 32'(note_def), 32'd0);
    check("def busy", 32'(busy_def), 32'd1);
    check("def state", 32'(state_def), 32'd2);
    check("def done", 32'(done_def), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
